// File: rtl/fpu_op_issuer.sv
// fpu_op_issuer: queues FPU operation commands, drives each one into a
// combinational FPU, holds the inputs until the datapath has settled, then
// captures the result and flags and returns them, tagged, in command order.
module fpu_op_issuer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sp_dp,
    input  logic [1:0]       cmd_op,
    input  logic [63:0]      cmd_a,
    input  logic [63:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             fpu_sp_dp,
    output logic [1:0]       fpu_opCode,
    output logic [31:0]      fpu_a_sp,
    output logic [31:0]      fpu_b_sp,
    output logic [63:0]      fpu_a_dp,
    output logic [63:0]      fpu_b_dp,
    input  logic [31:0]      fpu_result_sp,
    input  logic [63:0]      fpu_result_dp,
    input  logic             fpu_overflow,
    input  logic             fpu_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef struct packed {
        logic             sp_dp;
        logic [1:0]       op;
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    // Command queue: pointers carry one extra wrap bit to tell full from empty.
    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    cmd_t             push_entry;
    cmd_t             head_entry;

    // Operation currently presented to the FPU; only a pop changes it.
    cmd_t             drive;
    logic [CNT_W-1:0] cnt;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign push_entry = {cmd_sp_dp, cmd_op, cmd_a, cmd_b, cmd_tag};
    assign head_entry = mem[rd_ptr[PTR_W-1:0]];

    assign fpu_sp_dp  = drive.sp_dp;
    assign fpu_opCode = drive.op;
    assign fpu_a_sp   = drive.a[31:0];
    assign fpu_b_sp   = drive.b[31:0];
    assign fpu_a_dp   = drive.a;
    assign fpu_b_dp   = drive.b;

    assign busy       = (state != IDLE) || !empty;

    // Queue storage write; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    // Queue pointers; a simultaneous push and pop both advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, pop and capture decisions.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = WAIT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Drive registers, settle counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive         <= '0;
            cnt           <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_tag       <= '0;
        end else begin
            if (pop) begin
                drive <= head_entry;
                cnt   <= CNT_W'(SETTLE_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (capture) begin
                rsp_valid     <= 1'b1;
                rsp_result    <= drive.sp_dp ? fpu_result_dp : {32'b0, fpu_result_sp};
                rsp_overflow  <= fpu_overflow;
                rsp_underflow <= fpu_underflow;
                rsp_tag       <= drive.tag;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_op_issuer.sv
// Bench for fpu_op_issuer: a stub FPU, a timeline model of the issuer
// checked every cycle, and directed scenarios with literal expectations.
module tb_fpu_op_issuer;

    localparam int SETTLE = 2;
    localparam int DEPTH  = 4;
    localparam int TW     = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_sp_dp;
    logic [1:0]    cmd_op;
    logic [63:0]   cmd_a;
    logic [63:0]   cmd_b;
    logic [TW-1:0] cmd_tag;
    logic          fpu_sp_dp;
    logic [1:0]    fpu_opCode;
    logic [31:0]   fpu_a_sp;
    logic [31:0]   fpu_b_sp;
    logic [63:0]   fpu_a_dp;
    logic [63:0]   fpu_b_dp;
    logic [31:0]   fpu_result_sp;
    logic [63:0]   fpu_result_dp;
    logic          fpu_overflow;
    logic          fpu_underflow;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_result;
    logic          rsp_overflow;
    logic          rsp_underflow;
    logic [TW-1:0] rsp_tag;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fpu_op_issuer #(
        .SETTLE_CYCLES(SETTLE),
        .FIFO_DEPTH   (DEPTH),
        .TAG_W        (TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_sp_dp    (cmd_sp_dp),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .fpu_sp_dp    (fpu_sp_dp),
        .fpu_opCode   (fpu_opCode),
        .fpu_a_sp     (fpu_a_sp),
        .fpu_b_sp     (fpu_b_sp),
        .fpu_a_dp     (fpu_a_dp),
        .fpu_b_dp     (fpu_b_dp),
        .fpu_result_sp(fpu_result_sp),
        .fpu_result_dp(fpu_result_dp),
        .fpu_overflow (fpu_overflow),
        .fpu_underflow(fpu_underflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_underflow(rsp_underflow),
        .rsp_tag      (rsp_tag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub FPU: exact answers for the known vectors, a deterministic scramble otherwise.
    typedef struct packed {
        logic        ovf;
        logic        unf;
        logic [63:0] rd;
        logic [31:0] rs;
    } fres_t;

    function automatic fres_t fpu_fn(input logic dp, input logic [1:0] op,
                                     input logic [63:0] a, input logic [63:0] b);
        fres_t r;
        r.rs  = a[31:0] ^ {b[15:0], b[31:16]} ^ {30'd0, op};
        r.rd  = {~r.rs, r.rs} ^ a ^ {b[31:0], b[63:32]};
        r.ovf = a[0] & b[0];
        r.unf = a[1] & ~b[1];
        if (!dp && op == 2'b00 && a[31:0] == 32'h3F800000 && b[31:0] == 32'h40000000) begin
            r.rs = 32'h40400000; r.rd = 64'hDEADBEEF_00000001; r.ovf = 1'b0; r.unf = 1'b0;
        end
        if (dp && op == 2'b10 && a == 64'h3FF8000000000000 && b == 64'h4000000000000000) begin
            r.rd = 64'h4008000000000000; r.rs = 32'hBAD0BAD0; r.ovf = 1'b0; r.unf = 1'b0;
        end
        if (!dp && op == 2'b10 && a[31:0] == 32'h7F000000 && b[31:0] == 32'h7F000000) begin
            r.rs = 32'h7F800000; r.rd = 64'hDEADBEEF_00000002; r.ovf = 1'b1; r.unf = 1'b0;
        end
        return r;
    endfunction

    fres_t stub;
    always_comb begin
        stub = fpu_fn(fpu_sp_dp, fpu_opCode,
                      fpu_sp_dp ? fpu_a_dp : {32'b0, fpu_a_sp},
                      fpu_sp_dp ? fpu_b_dp : {32'b0, fpu_b_sp});
    end
    assign fpu_result_sp = stub.rs;
    assign fpu_result_dp = stub.rd;
    assign fpu_overflow  = stub.ovf;
    assign fpu_underflow = stub.unf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: accepted commands, index of the oldest unanswered one, last handshake edge.
    int            acc_e [64];
    logic          c_sp  [64];
    logic [1:0]    c_op  [64];
    logic [63:0]   c_a   [64];
    logic [63:0]   c_b   [64];
    logic [TW-1:0] c_tag [64];
    int            n_acc   = 0;
    int            head    = 0;
    int            last_hs = 0;

    int            acc_q [$];
    int            rise_q[$];
    int            len_q [$];
    logic [63:0]   hs_res[$];
    logic          hs_ovf[$];
    logic          hs_unf[$];
    logic [TW-1:0] hs_tag[$];
    logic          prev_valid = 1'b0;
    int            hi_len = 0;

    int            st, queued, di;
    logic          has, started, e_ready, e_valid;
    logic          e_sp;
    logic [1:0]    e_op;
    logic [63:0]   e_a, e_b, e_res;
    fres_t         fr;

    // Compare process: each command starts max(accept+1, previous handshake),
    // answers SETTLE cycles later and stays valid until its handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_acc = 0; head = 0; last_hs = 0;
        end
        has = (head < n_acc);
        st  = 0;
        if (has) st = (acc_e[head] + 1 > last_hs) ? acc_e[head] + 1 : last_hs;
        started = has && (st <= cyc);
        queued  = n_acc - head - (started ? 1 : 0);
        e_ready = (queued < DEPTH);
        e_valid = has && (cyc >= st + SETTLE);
        di      = started ? head : head - 1;

        check("cmd_ready", {63'b0, cmd_ready}, {63'b0, e_ready});
        check("busy", {63'b0, busy}, {63'b0, has});
        check("rsp_valid", {63'b0, rsp_valid}, {63'b0, e_valid});

        if (di >= 0) begin
            e_sp = c_sp[di]; e_op = c_op[di]; e_a = c_a[di]; e_b = c_b[di];
        end else begin
            e_sp = 1'b0; e_op = 2'b00; e_a = '0; e_b = '0;
        end
        check("fpu_sp_dp", {63'b0, fpu_sp_dp}, {63'b0, e_sp});
        check("fpu_opCode", {62'b0, fpu_opCode}, {62'b0, e_op});
        check("fpu_a_dp", fpu_a_dp, e_a);
        check("fpu_b_dp", fpu_b_dp, e_b);
        check("fpu_a_sp", {32'b0, fpu_a_sp}, {32'b0, e_a[31:0]});
        check("fpu_b_sp", {32'b0, fpu_b_sp}, {32'b0, e_b[31:0]});

        if (e_valid) begin
            fr = fpu_fn(c_sp[head], c_op[head],
                        c_sp[head] ? c_a[head] : {32'b0, c_a[head][31:0]},
                        c_sp[head] ? c_b[head] : {32'b0, c_b[head][31:0]});
            e_res = c_sp[head] ? fr.rd : {32'b0, fr.rs};
            check("rsp_result", rsp_result, e_res);
            check("rsp_overflow", {63'b0, rsp_overflow}, {63'b0, fr.ovf});
            check("rsp_underflow", {63'b0, rsp_underflow}, {63'b0, fr.unf});
            check("rsp_tag", {{(64-TW){1'b0}}, rsp_tag}, {{(64-TW){1'b0}}, c_tag[head]});
        end

        if (rsp_valid && !prev_valid) begin
            rise_q.push_back(cyc);
            hi_len = 1;
        end else if (rsp_valid) begin
            hi_len++;
        end
        if (!rsp_valid && prev_valid) len_q.push_back(hi_len);
        prev_valid = rsp_valid;

        if (rst_n) begin
            if (cmd_valid && e_ready) begin
                acc_e[n_acc] = cyc + 1;
                c_sp[n_acc]  = cmd_sp_dp;
                c_op[n_acc]  = cmd_op;
                c_a[n_acc]   = cmd_a;
                c_b[n_acc]   = cmd_b;
                c_tag[n_acc] = cmd_tag;
                acc_q.push_back(cyc + 1);
                n_acc++;
            end
            if (e_valid && rsp_ready) begin
                hs_res.push_back(rsp_result);
                hs_ovf.push_back(rsp_overflow);
                hs_unf.push_back(rsp_underflow);
                hs_tag.push_back(rsp_tag);
                head++;
                last_hs = cyc + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sp, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [TW-1:0] tag);
        int n;
        cmd_sp_dp = sp; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", {63'b0, cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_res.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hs_wait", {63'b0, hs_res.size() >= target}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

    int base, r0, a0, l0;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sp_dp = 1'b0; cmd_op = 2'b00;
        cmd_a = '0; cmd_b = '0; cmd_tag = '0; rsp_ready = 1'b0;
        step(2);
        check("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("reset_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_rsp_result", rsp_result, 64'd0);
        check("reset_fpu_a_dp", fpu_a_dp, 64'd0);
        rst_n = 1'b1;
        step(1);

        // 1: SP add, 3-cycle latency
        rsp_ready = 1'b1;
        base = hs_res.size(); r0 = rise_q.size(); a0 = acc_q.size();
        push(1'b0, 2'b00, 64'h3F800000, 64'h40000000, 4'd3);
        wait_hs(base + 1);
        step(2);
        check("t1_latency", 64'(rise_q[r0] - acc_q[a0]), 64'd3);
        check("t1_result", hs_res[base], 64'h0000000040400000);
        check("t1_ovf", {63'b0, hs_ovf[base]}, 64'd0);
        check("t1_unf", {63'b0, hs_unf[base]}, 64'd0);
        check("t1_tag", {60'b0, hs_tag[base]}, 64'd3);

        // 2: DP mul, drive stable through WAIT
        base = hs_res.size();
        push(1'b1, 2'b10, 64'h3FF8000000000000, 64'h4000000000000000, 4'd5);
        step(1);
        check("t2_sp_dp_w1", {63'b0, fpu_sp_dp}, 64'd1);
        check("t2_op_w1", {62'b0, fpu_opCode}, 64'd2);
        step(1);
        check("t2_sp_dp_w2", {63'b0, fpu_sp_dp}, 64'd1);
        check("t2_op_w2", {62'b0, fpu_opCode}, 64'd2);
        wait_hs(base + 1);
        step(2);
        check("t2_result", hs_res[base], 64'h4008000000000000);

        // 3: stalled consumer, queue fills at 5
        rsp_ready = 1'b0;
        base = hs_res.size();
        for (int i = 0; i < 5; i++)
            push(1'b0, 2'(i), 64'h3F800000 + 64'(i), 64'h3, 4'(6 + i));
        cmd_sp_dp = 1'b0; cmd_op = 2'b01; cmd_a = 64'h55; cmd_b = 64'h66; cmd_tag = 4'd2;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_full_ready", {63'b0, cmd_ready}, 64'd0);
            check("t3_stall_valid", {63'b0, rsp_valid}, 64'd1);
            check("t3_stall_tag", {60'b0, rsp_tag}, 64'd6);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_hs(base + 5);
        step(2);
        for (int k = 0; k < 5; k++)
            check("t3_tag_order", {60'b0, hs_tag[base + k]}, 64'(6 + k));

        // 4: SP overflow captured and held
        rsp_ready = 1'b0;
        base = hs_res.size();
        push(1'b0, 2'b10, 64'h7F000000, 64'h7F000000, 4'd1);
        step(5);
        check("t4_valid", {63'b0, rsp_valid}, 64'd1);
        check("t4_ovf", {63'b0, rsp_overflow}, 64'd1);
        check("t4_unf", {63'b0, rsp_underflow}, 64'd0);
        step(2);
        check("t4_ovf_held", {63'b0, rsp_overflow}, 64'd1);
        check("t4_result", rsp_result, 64'h000000007F800000);
        rsp_ready = 1'b1;
        wait_hs(base + 1);
        step(2);

        // 5: reset in WAIT with two queued
        rsp_ready = 1'b0;
        push(1'b1, 2'b11, 64'hC000000000000001, 64'h4010000000000003, 4'd11);
        push(1'b1, 2'b11, 64'h1, 64'h2, 4'd12);
        push(1'b0, 2'b01, 64'h3, 64'h4, 4'd13);
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("t5_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        check("t5_busy", {63'b0, busy}, 64'd0);
        check("t5_fpu_a_dp", fpu_a_dp, 64'd0);
        check("t5_fpu_b_sp", {32'b0, fpu_b_sp}, 64'd0);
        check("t5_fpu_op", {62'b0, fpu_opCode}, 64'd0);
        check("t5_fpu_sp_dp", {63'b0, fpu_sp_dp}, 64'd0);
        step(2);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        r0 = rise_q.size();
        step(20);
        check("t5_no_response", 64'(rise_q.size()), 64'(r0));
        check("t5_idle_busy", {63'b0, busy}, 64'd0);

        // 6: back-to-back at full rate
        base = hs_res.size(); r0 = rise_q.size(); l0 = len_q.size();
        push(1'b0, 2'b00, 64'h12345678, 64'h9ABCDEF0, 4'd14);
        push(1'b1, 2'b01, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'd15);
        wait_hs(base + 2);
        step(3);
        check("t6_spacing", 64'(rise_q[r0 + 1] - rise_q[r0]), 64'd3);
        check("t6_len0", 64'(len_q[l0]), 64'd1);
        check("t6_len1", 64'(len_q[l0 + 1]), 64'd1);
        check("t6_tag0", {60'b0, hs_tag[base]}, 64'd14);
        check("t6_tag1", {60'b0, hs_tag[base + 1]}, 64'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
